hstx_multilane_seq: RTL and testbench
=====================================

# hstx_multilane_seq

Parametrised multi-lane HS transmit sequencer in the byte-clock domain. It accepts `LANES` bytes per word and generates each lane's HS byte stream: HS-Prepare gap, HS-Zero, SoT sync byte, payload and per-lane HS-Trail. Each lane ends independently on a partial last word. Its outputs feed one serializer and DDR output stage per lane.

## Interface
Parameters:
- `LANES`, 2: number of data lanes, 1..4.
- `CNT_W`, 8: width of the timing-count inputs.

Ports:
- `TxByteClkHS`  in  1: byte clock, the only clock.
- `TxRst`  in  1: reset, asynchronous and active-high.
- `TxRequestHS`  in  1: level request for an HS burst.
- `TxValid`  in  1: a word is offered on `TxByte_Data`.
- `TxLast`  in  1: the offered word is the final word of the burst.
- `TxByteEn`  in  LANES: lane-valid mask for the offered word. It is contiguous from lane 0 and all ones unless `TxLast` is high.
- `TxByte_Data`  in  8*LANES: lane i byte is `[8i+7:8i]`.
- `cfg_prep`, `cfg_zero`, `cfg_trail`, `cfg_exit`  in  CNT_W each: timing counts in byte-clock cycles. A value of 0 is treated as 1.
- `TxReady`  out  1: a word is accepted this cycle when `TxValid` is high.
- `HS_Bytes`  out  8*LANES: per-lane byte to the serializers.
- `HS_En`  out  LANES: per-lane serializer/driver enable.
- `TxState`  out  3: encodings are IDLE 000, PREPARE 001, ZERO 010, DATA 011, TRAIL 100, EXIT 101, SYNC 110.
- `TxUnderrun`  out  1: one-cycle error pulse.

## Operation
- Reset value of every output is 0, and the state is IDLE.
- All outputs are registered.
- The `cfg_*` inputs are latched on the IDLE→PREPARE transition and ignored for the rest of the burst.
- IDLE: when `TxRequestHS` is sampled high, the block moves to PREPARE.
- PREPARE lasts P cycles. `HS_En`=0 and `HS_Bytes`=0 throughout.
- ZERO lasts Z cycles. `HS_En` is all ones and all lanes drive 0x00.
- SYNC lasts 1 cycle. All lanes drive 0xB8 and `TxReady`=1.
- DATA: `TxReady`=1. Each accepted word appears on `HS_Bytes` on the next cycle, so words are output back-to-back.
- End of burst occurs when the last word is accepted:
  - Lanes with `TxByteEn`=0 enter trail on the same cycle the word is output.
  - Lanes with `TxByteEn`=1 enter trail one cycle later.
- Trail:
  - Each lane drives `{8{~b}}` for T cycles, where b is bit 7 of that lane's last transmitted byte. Bit 7 is the last serialized bit because transmission is LSB first.
  - A lane that sent no payload uses 0xB8 as its last byte, so it drives 0x00.
  - After its T cycles each lane drops its `HS_En` bit; from then on its byte is 0x00.
- TxState:
  - It shows TRAIL from the first cycle in which any lane is trailing.
  - It changes to EXIT once all `HS_En` bits are 0.
  - It then holds EXIT with `HS_En` at 0 for X cycles and returns to IDLE.
  - If `TxRequestHS` is still high in IDLE, the next burst starts.
- Underrun: if `TxValid` is low while `TxReady` is high (SYNC or DATA), the block pulses `TxUnderrun` and behaves as if `TxLast` had arrived with `TxByteEn`=0. All lanes then trail based on the previously output byte.
- Abort:
  - `TxRequestHS` low in PREPARE: return to IDLE on the next cycle, with no HS drive.
  - `TxRequestHS` low in ZERO: all lanes trail with 0xFF (the last bit sent was 0) for T cycles, then EXIT.
  - `TxRequestHS` is ignored from SYNC onward; only `TxLast` or an underrun ends the burst.
- Asynchronous reset asserted mid-burst: all outputs are forced to 0 immediately. No trail is produced.

## Timing
- Request sampled at cycle 0:
  - Output cycles 1..P: PREPARE.
  - Cycles P+1..P+Z: ZERO.
  - Cycle P+Z+1: SYNC, 0xB8.
  - First payload appears at P+Z+2.
- Last word accepted at cycle L:
  - Lanes with `TxByteEn`=0 trail during cycles L+1..L+T.
  - Lanes with `TxByteEn`=1 output payload at L+1 and trail during L+2..L+T+1.
  - EXIT during L+T+2..L+T+X+1; IDLE at L+T+X+2.
- Accept-to-output latency is 1 cycle. No buffering; backpressure is never applied inside DATA.

## Structure
- Package `hstx_pkg`:
  - state encodings;
  - `SYNC_BYTE`=8'hB8;
  - `CNT_W` default;
  - the `LANES` maximum.
- Sub-module `hstx_lane_tail`, instantiated once per lane:
  - holds the byte register, last-bit tracking and trail counter;
  - drives its own `HS_En` bit and signals trail-done.
- Top level: one FSM, one shared timing counter, and the AND-reduction of the lanes' trail-done signals.

## Test plan
- LANES=2, P=2/Z=3/T=4/X=2. Send 3 full words {0x11,0x22}, {0x33,0x44}, {0x55,0x66}, the last with `TxLast`:
  - Outputs are 2 cycles with `HS_En`=0, 3 cycles of 0x00, then 0xB8.
  - The 3 data words follow back-to-back.
  - Both lanes then trail 0xFF×4 (bit 7 of 0x55 and 0x66 is 0).
  - EXIT lasts 2 cycles, then IDLE.
- LANES=4, last word with `TxByteEn`=0011 and lane 2's previous byte 0x80:
  - Lanes 2 and 3 enter trail one cycle before lanes 0 and 1.
  - Lane 2 trails 0x00.
  - Lanes 2 and 3 drop `HS_En` one cycle before lanes 0 and 1.
  - TxState shows TRAIL from the first trailing cycle and EXIT only after all lanes finish.
- `TxValid` dropped for one cycle in mid-DATA:
  - `TxUnderrun` pulses once.
  - All lanes trail based on the prior word, then EXIT.
- `TxRequestHS` low during PREPARE: IDLE on the next cycle with `HS_En` never asserted. Low during ZERO: 0xFF trail for T cycles, then EXIT.
- `cfg_*`=0: every phase lasts 1 cycle. Changing `cfg_*` mid-burst has no effect.
- `TxRst` pulsed during DATA: all outputs are 0 immediately. After release the block is in IDLE and a new request runs a clean burst.

Source files
------------

// File: rtl/hstx_pkg.sv
// Shared definitions for the multi-lane HS transmit sequencer.
package hstx_pkg;

    // Sequencer state, also presented directly on TxState.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_PREPARE = 3'b001,
        ST_ZERO    = 3'b010,
        ST_DATA    = 3'b011,
        ST_TRAIL   = 3'b100,
        ST_EXIT    = 3'b101,
        ST_SYNC    = 3'b110
    } hstx_state_e;

    // Start-of-transmission sync byte sent on every lane after HS-Zero.
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // Default width of the timing-count inputs.
    localparam int CNT_W_DEF = 8;

    // Largest supported number of data lanes.
    localparam int LANES_MAX = 4;

endpackage

// File: rtl/hstx_lane_tail.sv
// One lane's output byte register, last-bit tracking and HS-Trail counter.
// The top tells the lane what to drive next; the lane ends its own trail.
module hstx_lane_tail
    import hstx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_zero_i,
    input  logic             load_sync_i,
    input  logic             load_data_i,
    input  logic [7:0]       data_i,
    input  logic             start_trail_i,
    input  logic [CNT_W-1:0] trail_len_i,
    output logic [7:0]       byte_o,
    output logic             en_o,
    output logic             done_o
);

    logic [7:0]       byte_q, byte_d;
    logic             en_q, en_d;
    logic             trailing_q, trailing_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: loads take priority; a trail request is honoured only by a
    // lane that is still driving and not already trailing, so the top can
    // broadcast it to every lane without disturbing finished ones.
    always_comb begin
        byte_d     = byte_q;
        en_d       = en_q;
        trailing_d = trailing_q;
        cnt_d      = cnt_q;
        if (load_zero_i) begin
            byte_d = 8'h00;
            en_d   = 1'b1;
        end else if (load_sync_i) begin
            byte_d = SYNC_BYTE;
            en_d   = 1'b1;
        end else if (load_data_i) begin
            byte_d = data_i;
            en_d   = 1'b1;
        end else if (start_trail_i && en_q && !trailing_q) begin
            // Trail level is the inverse of the last serialized bit (bit 7, LSB-first link).
            byte_d     = {8{~byte_q[7]}};
            trailing_d = 1'b1;
            cnt_d      = trail_len_i - CNT_W'(1);
        end else if (trailing_q) begin
            if (cnt_q == '0) begin
                trailing_d = 1'b0;
                en_d       = 1'b0;
                byte_d     = 8'h00;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_q     <= 8'h00;
            en_q       <= 1'b0;
            trailing_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            byte_q     <= byte_d;
            en_q       <= en_d;
            trailing_q <= trailing_d;
            cnt_q      <= cnt_d;
        end
    end

    assign byte_o = byte_q;
    assign en_o   = en_q;
    // Done means the lane will be disabled from the next cycle on.
    assign done_o = trailing_q ? (cnt_q == '0) : ~en_q;

endmodule

// File: rtl/hstx_multilane_seq.sv
// Multi-lane HS transmit sequencer: one FSM with a shared phase counter
// driving LANES per-lane byte/trail engines. LANES must be 1..LANES_MAX.
module hstx_multilane_seq
    import hstx_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 TxByteClkHS,
    input  logic                 TxRst,
    input  logic                 TxRequestHS,
    input  logic                 TxValid,
    input  logic                 TxLast,
    input  logic [LANES-1:0]     TxByteEn,
    input  logic [8*LANES-1:0]   TxByte_Data,
    input  logic [CNT_W-1:0]     cfg_prep,
    input  logic [CNT_W-1:0]     cfg_zero,
    input  logic [CNT_W-1:0]     cfg_trail,
    input  logic [CNT_W-1:0]     cfg_exit,
    output logic                 TxReady,
    output logic [8*LANES-1:0]   HS_Bytes,
    output logic [LANES-1:0]     HS_En,
    output logic [2:0]           TxState,
    output logic                 TxUnderrun
);

    hstx_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] zero_q, zero_d;
    logic [CNT_W-1:0] trail_q, trail_d;
    logic [CNT_W-1:0] exit_q, exit_d;
    logic             ready_q, ready_d;
    logic             underrun_q, underrun_d;

    logic             lane_zero;
    logic             lane_sync;
    logic [LANES-1:0] lane_data;
    logic [LANES-1:0] lane_trail;
    logic [LANES-1:0] lane_done;

    // A programmed count of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Sequencer next-state and per-lane control decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        trail_d    = trail_q;
        exit_d     = exit_q;
        ready_d    = 1'b0;
        underrun_d = 1'b0;
        lane_zero  = 1'b0;
        lane_sync  = 1'b0;
        lane_data  = '0;
        lane_trail = '0;
        case (state_q)
            ST_IDLE: begin
                if (TxRequestHS) begin
                    state_d = ST_PREPARE;
                    cnt_d   = at_least_one(cfg_prep) - CNT_W'(1);
                    zero_d  = at_least_one(cfg_zero);
                    trail_d = at_least_one(cfg_trail);
                    exit_d  = at_least_one(cfg_exit);
                end
            end
            ST_PREPARE: begin
                // Dropping the request here leaves the line untouched.
                if (!TxRequestHS) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d   = ST_ZERO;
                    cnt_d     = zero_q - CNT_W'(1);
                    lane_zero = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ZERO: begin
                // Abort during HS-Zero still ends with a proper trail.
                if (!TxRequestHS) begin
                    state_d    = ST_TRAIL;
                    lane_trail = '1;
                end else if (cnt_q == '0) begin
                    state_d   = ST_SYNC;
                    lane_sync = 1'b1;
                    ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYNC, ST_DATA: begin
                if (!ready_q) begin
                    // Full last word is on the lanes now; all of them trail next.
                    state_d    = ST_TRAIL;
                    lane_trail = '1;
                end else if (!TxValid) begin
                    state_d    = ST_TRAIL;
                    underrun_d = 1'b1;
                    lane_trail = '1;
                end else if (TxLast) begin
                    // Unused lanes start trailing while the others send their last byte.
                    lane_data  = TxByteEn;
                    lane_trail = ~TxByteEn;
                    state_d    = (&TxByteEn) ? ST_DATA : ST_TRAIL;
                end else begin
                    lane_data = '1;
                    ready_d   = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_TRAIL: begin
                // Broadcast keeps late lanes joining; finished lanes ignore it.
                lane_trail = '1;
                if (&lane_done) begin
                    state_d = ST_EXIT;
                    cnt_d   = exit_q - CNT_W'(1);
                end
            end
            ST_EXIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset silences the link immediately.
    always_ff @(posedge TxByteClkHS or posedge TxRst) begin
        if (TxRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            zero_q     <= '0;
            trail_q    <= '0;
            exit_q     <= '0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
            trail_q    <= trail_d;
            exit_q     <= exit_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        hstx_lane_tail #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk_i         (TxByteClkHS),
            .rst_i         (TxRst),
            .load_zero_i   (lane_zero),
            .load_sync_i   (lane_sync),
            .load_data_i   (lane_data[gi]),
            .data_i        (TxByte_Data[8*gi +: 8]),
            .start_trail_i (lane_trail[gi]),
            .trail_len_i   (trail_q),
            .byte_o        (HS_Bytes[8*gi +: 8]),
            .en_o          (HS_En[gi]),
            .done_o        (lane_done[gi])
        );
    end

    assign TxState    = state_q;
    assign TxReady    = ready_q;
    assign TxUnderrun = underrun_q;

endmodule

// File: tb/tb_hstx_multilane_seq.sv
// Bench for hstx_multilane_seq: a 2-lane and a 4-lane instance, per-cycle
// expected outputs pushed to a scoreboard queue and compared on the falling edge.
module tb_hstx_multilane_seq;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_ZERO  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_EXIT  = 3'd5;
    localparam logic [2:0] S_SYNC  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req2 = 1'b0, req4 = 1'b0, valid = 1'b0, last = 1'b0;
    logic [1:0]  be2 = 2'b11;
    logic [3:0]  be4 = 4'b1111;
    logic [15:0] data2 = '0;
    logic [31:0] data4 = '0;
    logic [7:0]  c_prep = 8'd1, c_zero = 8'd1, c_trail = 8'd1, c_exit = 8'd1;

    logic        rdy2, und2, rdy4, und4;
    logic [15:0] by2;
    logic [31:0] by4;
    logic [1:0]  en2;
    logic [3:0]  en4;
    logic [2:0]  st2, st4;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    hstx_multilane_seq #(.LANES(2), .CNT_W(8)) dut2 (
        .TxByteClkHS(clk), .TxRst(rst), .TxRequestHS(req2), .TxValid(valid), .TxLast(last),
        .TxByteEn(be2), .TxByte_Data(data2), .cfg_prep(c_prep), .cfg_zero(c_zero),
        .cfg_trail(c_trail), .cfg_exit(c_exit), .TxReady(rdy2), .HS_Bytes(by2),
        .HS_En(en2), .TxState(st2), .TxUnderrun(und2)
    );

    hstx_multilane_seq #(.LANES(4), .CNT_W(8)) dut4 (
        .TxByteClkHS(clk), .TxRst(rst), .TxRequestHS(req4), .TxValid(valid), .TxLast(last),
        .TxByteEn(be4), .TxByte_Data(data4), .cfg_prep(c_prep), .cfg_zero(c_zero),
        .cfg_trail(c_trail), .cfg_exit(c_exit), .TxReady(rdy4), .HS_Bytes(by4),
        .HS_En(en4), .TxState(st4), .TxUnderrun(und4)
    );

    // Pack an expected output vector: {state, ready, underrun, en[3:0], bytes[31:0]}.
    function automatic logic [63:0] ex(input logic [2:0] st, input logic rdy, input logic und,
                                       input logic [3:0] en, input logic [31:0] by);
        return {23'b0, st, rdy, und, en, by};
    endfunction

    function automatic logic [63:0] obs2();
        return {23'b0, st2, rdy2, und2, 2'b00, en2, 16'h0000, by2};
    endfunction

    function automatic logic [63:0] obs4();
        return {23'b0, st4, rdy4, und4, en4, by4};
    endfunction

    // Drive one cycle of 2-lane stimulus, then return the outputs of the following cycle.
    task automatic cyc2(input logic r, input logic v, input logic l, input logic [15:0] d,
                        output logic [63:0] obs);
        req2 = r; valid = v; last = l; data2 = d; be2 = 2'b11;
        @(negedge clk);
        obs = obs2();
    endtask

    task automatic cyc4(input logic r, input logic v, input logic l, input logic [3:0] be,
                        input logic [31:0] d, output logic [63:0] obs);
        req4 = r; valid = v; last = l; be4 = be; data4 = d;
        @(negedge clk);
        obs = obs4();
    endtask

    task automatic test_reset();
        logic [63:0] e;
        #1 rst = 1'b1;
        #2;
        sb.push_back(64'h0);
        e = sb.pop_front();
        checks++;
        if (obs2() !== e) begin failures++; $display("FAIL reset2 got=%h expected=%h", obs2(), e); end
        else $display("ok reset2 out=%h", obs2());
        sb.push_back(64'h0);
        e = sb.pop_front();
        checks++;
        if (obs4() !== e) begin failures++; $display("FAIL reset4 got=%h expected=%h", obs4(), e); end
        else $display("ok reset4 out=%h", obs4());
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd2; c_zero = 8'd3; c_trail = 8'd4; c_exit = 8'd2;
        for (int t = 0; t <= 17; t++) begin
            n = t + 1;
            if (n <= 2)       e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n <= 5)  e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n == 6)  e = ex(S_SYNC, 1'b1, 1'b0, 4'h3, 32'hB8B8);
            else if (n == 7)  e = ex(S_DATA, 1'b1, 1'b0, 4'h3, 32'h2211);
            else if (n == 8)  e = ex(S_DATA, 1'b1, 1'b0, 4'h3, 32'h4433);
            else if (n == 9)  e = ex(S_DATA, 1'b0, 1'b0, 4'h3, 32'h6655);
            else if (n <= 13) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'hFFFF);
            else if (n <= 15) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else              e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc2(t <= 6, t >= 6 && t <= 8, t == 8,
                 (t == 6) ? 16'h2211 : (t == 7) ? 16'h4433 : 16'h6655, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL basic cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok basic cycle=%0d out=%h", n, obs);
        end
    endtask

    task automatic test_partial();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd1; c_zero = 8'd1; c_trail = 8'd3; c_exit = 8'd1;
        for (int t = 0; t <= 10; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n == 2) e = ex(S_ZERO, 1'b0, 1'b0, 4'hF, 32'h0);
            else if (n == 3) e = ex(S_SYNC, 1'b1, 1'b0, 4'hF, 32'hB8B8B8B8);
            else if (n == 4) e = ex(S_DATA, 1'b1, 1'b0, 4'hF, 32'h44802211);
            else if (n == 5) e = ex(S_TRAIL, 1'b0, 1'b0, 4'hF, 32'hFF006655);
            else if (n <= 7) e = ex(S_TRAIL, 1'b0, 1'b0, 4'hF, 32'hFF00FFFF);
            else if (n == 8) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'h0000FFFF);
            else if (n == 9) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else             e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc4(t <= 3, t == 3 || t == 4, t == 4, (t == 4) ? 4'b0011 : 4'b1111,
                 (t == 3) ? 32'h44802211 : 32'hBBAA6655, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL partial cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok partial cycle=%0d out=%h", n, obs);
        end
        be4 = 4'b1111;
    endtask

    task automatic test_underrun();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd1; c_zero = 8'd1; c_trail = 8'd2; c_exit = 8'd1;
        for (int t = 0; t <= 9; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n == 2) e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n == 3) e = ex(S_SYNC, 1'b1, 1'b0, 4'h3, 32'hB8B8);
            else if (n == 4) e = ex(S_DATA, 1'b1, 1'b0, 4'h3, 32'h0102);
            else if (n == 5) e = ex(S_DATA, 1'b1, 1'b0, 4'h3, 32'h8112);
            else if (n == 6) e = ex(S_TRAIL, 1'b0, 1'b1, 4'h3, 32'h00FF);
            else if (n == 7) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'h00FF);
            else if (n == 8) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else             e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc2(t <= 3, t == 3 || t == 4 || t == 6, 1'b0, (t == 3) ? 16'h0102 : 16'h8112, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL underrun cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok underrun cycle=%0d out=%h", n, obs);
        end
    endtask

    task automatic test_abort_prep();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd3; c_zero = 8'd1; c_trail = 8'd1; c_exit = 8'd1;
        for (int t = 0; t <= 3; t++) begin
            n = t + 1;
            e = (n == 1) ? ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0) : ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc2(t == 0, 1'b0, 1'b0, 16'h0, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_prep cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok abort_prep cycle=%0d out=%h", n, obs);
        end
    endtask

    task automatic test_abort_zero();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd1; c_zero = 8'd4; c_trail = 8'd2; c_exit = 8'd1;
        for (int t = 0; t <= 6; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n <= 3) e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n <= 5) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'hFFFF);
            else if (n == 6) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else             e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc2(t <= 2, 1'b0, 1'b0, 16'h0, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_zero cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok abort_zero cycle=%0d out=%h", n, obs);
        end
    endtask

    task automatic test_cfg_zero();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd0; c_zero = 8'd0; c_trail = 8'd0; c_exit = 8'd0;
        for (int t = 0; t <= 6; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n == 2) e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n == 3) e = ex(S_SYNC, 1'b1, 1'b0, 4'h3, 32'hB8B8);
            else if (n == 4) e = ex(S_DATA, 1'b0, 1'b0, 4'h3, 32'h9A7F);
            else if (n == 5) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'h00FF);
            else if (n == 6) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else             e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            if (t >= 1) begin
                c_prep = 8'd9; c_zero = 8'd9; c_trail = 8'd9; c_exit = 8'd9;
            end
            cyc2(t <= 3, t == 3, t == 3, 16'h9A7F, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL cfg_zero cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok cfg_zero cycle=%0d out=%h", n, obs);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e, obs;
        int n;
        c_prep = 8'd1; c_zero = 8'd1; c_trail = 8'd1; c_exit = 8'd1;
        for (int t = 0; t <= 3; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n == 2) e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n == 3) e = ex(S_SYNC, 1'b1, 1'b0, 4'h3, 32'hB8B8);
            else             e = ex(S_DATA, 1'b1, 1'b0, 4'h3, 32'h3344);
            sb.push_back(e);
            cyc2(1'b1, t == 3, 1'b0, 16'h3344, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL rst_mid cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok rst_mid cycle=%0d out=%h", n, obs);
        end
        // Assert reset between clock edges: outputs must clear without a clock.
        #2 rst = 1'b1;
        #1;
        sb.push_back(64'h0);
        e = sb.pop_front();
        checks++;
        if (obs2() !== e) begin failures++; $display("FAIL rst_async got=%h expected=%h", obs2(), e); end
        else $display("ok rst_async out=%h", obs2());
        @(negedge clk);
        req2 = 1'b0; valid = 1'b0; rst = 1'b0;
        #1;
        sb.push_back(ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0));
        e = sb.pop_front();
        checks++;
        if (obs2() !== e) begin failures++; $display("FAIL rst_release got=%h expected=%h", obs2(), e); end
        else $display("ok rst_release out=%h", obs2());
        @(negedge clk);
        for (int t = 0; t <= 7; t++) begin
            n = t + 1;
            if (n == 1)      e = ex(S_PREP, 1'b0, 1'b0, 4'h0, 32'h0);
            else if (n == 2) e = ex(S_ZERO, 1'b0, 1'b0, 4'h3, 32'h0);
            else if (n == 3) e = ex(S_SYNC, 1'b1, 1'b0, 4'h3, 32'hB8B8);
            else if (n == 4) e = ex(S_DATA, 1'b0, 1'b0, 4'h3, 32'hC3D4);
            else if (n == 5) e = ex(S_TRAIL, 1'b0, 1'b0, 4'h3, 32'h0000);
            else if (n == 6) e = ex(S_EXIT, 1'b0, 1'b0, 4'h0, 32'h0);
            else             e = ex(S_IDLE, 1'b0, 1'b0, 4'h0, 32'h0);
            sb.push_back(e);
            cyc2(t <= 3, t == 3, t == 3, 16'hC3D4, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin failures++; $display("FAIL rst_clean cycle=%0d got=%h expected=%h", n, obs, e); end
            else $display("ok rst_clean cycle=%0d out=%h", n, obs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_underrun();
        test_abort_prep();
        test_abort_zero();
        test_cfg_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
